// File: rtl/dematrix_pkg.sv
// Shared types and constants for the Rijndael state (de)matrixing path.
// Latency: n/a (declarations only).  Backpressure: n/a.
// Contents: ROWS, BYTE_W, legal NB check, block width W(NB), byte order enum, fill FSM states.
package dematrix_pkg;

  localparam int ROWS   = 4;
  localparam int BYTE_W = 8;

  // Legal Rijndael column counts: 128, 192 and 256 bit blocks.
  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  typedef enum logic {
    COL_MAJOR = 1'b0,
    ROW_MAJOR = 1'b1
  } order_e;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fill_st_e;

  function automatic int block_w(input int nb);
    return ROWS * BYTE_W * nb;
  endfunction

  function automatic bit nb_is_legal(input int nb);
    return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
  endfunction

endpackage

// File: rtl/dematrix_slot.sv
// Maps the k-th streamed byte of a block to its flat column-major slot 4c+r.
// Latency: combinational.  Backpressure: none (pure function of inputs).
// Ports: i_k byte index 0..4*NB-1, i_order stream order, o_slot flat slot index.
module dematrix_slot
  import dematrix_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [$clog2(ROWS*NB)-1:0] i_k,
  input  order_e                     i_order,
  output logic [$clog2(ROWS*NB)-1:0] o_slot
);

  localparam int CW = $clog2(ROWS*NB);
  localparam logic [CW-1:0] NB_C   = CW'(NB);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

  always_comb begin
    o_slot = i_k;
    // Row-major stream: row = k/NB, column = k%NB. Column-major is identity.
    if (i_order == ROW_MAJOR) begin
      o_slot = ROWS_C * (i_k % NB_C) + (i_k / NB_C);
    end
  end

endmodule

// File: rtl/dematrixify_stream.sv
// Packs a byte stream into a 4 x NB Rijndael state and emits it as one flat column-major block.
// Latency: 1 cycle from the last-byte accept edge to out_valid (or from the drain edge when held).
// Backpressure: one full block buffered beyond the output register; in_ready drops only while a
//   complete block waits for the output slot. Optional DEMATRIX_FLUSH_EN adds a flush input.
// Ports: clk, reset (async high), in_data/in_valid/in_ready byte side, row_major order select,
//   out_block/out_valid/out_ready block side, flush (only when DEMATRIX_FLUSH_EN is defined).
module dematrixify_stream
  import dematrix_pkg::*;
#(
  parameter int NB     = 4,
  parameter int BYTE_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     row_major,
  output logic [ROWS*BYTE_W*NB-1:0] out_block,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef DEMATRIX_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int NBYTES = ROWS * NB;
  localparam int W      = ROWS * BYTE_W * NB;
  localparam int CW     = $clog2(NBYTES);

  fill_st_e          r_state;
  logic [CW-1:0]     r_count;
  order_e            r_order;
  logic [BYTE_W-1:0] r_buf [NBYTES];
  logic [W-1:0]      r_out_block;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_last;
  logic              w_slot_free;
  order_e            w_order;
  logic [CW-1:0]     w_slot;
  logic [W-1:0]      w_assembled;

  assign out_block = r_out_block;
  assign out_valid = r_out_valid;

`ifdef DEMATRIX_FLUSH_EN
  assign in_ready = (r_state == FILL) && !flush;
`else
  assign in_ready = (r_state == FILL);
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_count == CW'(NBYTES - 1));
  assign w_slot_free = !r_out_valid || out_ready;

  // Byte 0 uses the live order input; the rest of the block uses the latched copy.
  assign w_order = (r_count == '0) ? order_e'(row_major) : r_order;

  dematrix_slot #(
    .NB(NB)
  ) u_slot (
    .i_k    (r_count),
    .i_order(w_order),
    .o_slot (w_slot)
  );

  // Flat view of the fill buffer with the byte being accepted this cycle overlaid,
  // so the last byte can go straight to the output register on its own edge.
  always_comb begin
    w_assembled = '0;
    for (int s = 0; s < NBYTES; s++) begin
      if (w_accept && (w_slot == CW'(s))) begin
        w_assembled[W-1-BYTE_W*s -: BYTE_W] = in_data;
      end else begin
        w_assembled[W-1-BYTE_W*s -: BYTE_W] = r_buf[s];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_order     <= COL_MAJOR;
      r_out_block <= '0;
      r_out_valid <= 1'b0;
      for (int s = 0; s < NBYTES; s++) begin
        r_buf[s] <= '0;
      end
    end else begin
      // Drain by default; a load below on the same edge overrides this.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
`ifdef DEMATRIX_FLUSH_EN
      if (flush) begin
        r_count <= '0;
        r_state <= FILL;
      end else begin
`else
      begin
`endif
        case (r_state)
          FILL: begin
            if (w_accept) begin
              r_buf[w_slot] <= in_data;
              if (r_count == '0) begin
                r_order <= order_e'(row_major);
              end
              if (!w_last) begin
                r_count <= r_count + CW'(1);
              end else begin
                r_count <= '0;
                if (w_slot_free) begin
                  r_out_block <= w_assembled;
                  r_out_valid <= 1'b1;
                end else begin
                  r_state <= HOLD;
                end
              end
            end
          end
          HOLD: begin
            // in_ready is low here, so w_assembled is exactly the held buffer.
            if (w_slot_free) begin
              r_out_block <= w_assembled;
              r_out_valid <= 1'b1;
              r_state     <= FILL;
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

endmodule
